// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension unit: mode encodings and mode width.
package imm_ext_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] EXT_ZERO   = 2'd0;
    localparam logic [MODE_W-1:0] EXT_SIGN   = 2'd1;
    localparam logic [MODE_W-1:0] EXT_UPPER  = 2'd2;
    localparam logic [MODE_W-1:0] EXT_BRANCH = 2'd3;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender (zero / sign / upper / branch-offset).
// IMM_EXT_BRANCH_EN: when undefined, branch mode falls back to plain sign extension.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]   immediate,
    input  logic [MODE_W-1:0] extMode,
    output logic [OUT_W-1:0]  extended
);

    logic [OUT_W-1:0] zeroExt;
    logic [OUT_W-1:0] signExt;
    logic [OUT_W-1:0] upperExt;

    assign zeroExt  = {{(OUT_W-IN_W){1'b0}}, immediate};
    assign signExt  = {{(OUT_W-IN_W){immediate[IN_W-1]}}, immediate};
    assign upperExt = {immediate, {(OUT_W-IN_W){1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
    logic [OUT_W-1:0] branchExt;
    // Word-aligned offset: bits pushed past OUT_W are simply dropped.
    assign branchExt = signExt << 2;
`endif

    always_comb begin
        extended = zeroExt;
        case (extMode)
            EXT_ZERO:   extended = zeroExt;
            EXT_SIGN:   extended = signExt;
            EXT_UPPER:  extended = upperExt;
`ifdef IMM_EXT_BRANCH_EN
            EXT_BRANCH: extended = branchExt;
`else
            EXT_BRANCH: extended = signExt;
`endif
            default:    extended = zeroExt;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Buffered immediate extender: valid/ready input, DEPTH-entry result FIFO, valid/ready output.
// Optional IMM_EXT_BRANCH_EN enables the shifted branch-offset mode in imm_ext_core.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       Reset_n,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [IN_W-1:0]            Immediate,
    input  logic [MODE_W-1:0]          ExtMode,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [OUT_W-1:0]           ImExtend,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // InReady is registered, so it never depends combinationally on OutReady.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [OUT_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] countNext;
    logic [OUT_W-1:0] extResult;
    logic             pushEn;
    logic             popEn;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .immediate (Immediate),
        .extMode   (ExtMode),
        .extended  (extResult)
    );

    assign OutValid = (Count != '0);
    assign ImExtend = OutValid ? entries[headPtr] : '0;
    assign pushEn   = InValid && InReady;
    assign popEn    = OutValid && OutReady;

    always_comb begin
        countNext = Count;
        if (pushEn && !popEn) begin
            countNext = Count + CNT_W'(1);
        end else if (popEn && !pushEn) begin
            countNext = Count - CNT_W'(1);
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap to entry 0.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            headPtr <= '0;
            tailPtr <= '0;
            Count   <= '0;
            InReady <= 1'b0;
        end else begin
            if (pushEn) begin
                entries[tailPtr] <= extResult;
                tailPtr          <= tailPtr + PTR_W'(1);
            end
            if (popEn) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            Count   <= countNext;
            InReady <= (countNext < DEPTH_CNT);
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed cases plus random traffic against a queue model.
module tb_imm_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             CLK = 1'b0;
    logic             Reset_n;
    logic             InValid;
    logic             InReady;
    logic [IN_W-1:0]  Immediate;
    logic [1:0]       ExtMode;
    logic             OutValid;
    logic             OutReady;
    logic [OUT_W-1:0] ImExtend;
    logic [CNT_W-1:0] Count;

    always #5 CLK = ~CLK;

    imm_ext_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .Immediate (Immediate),
        .ExtMode   (ExtMode),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .ImExtend  (ImExtend),
        .Count     (Count)
    );

    int checkCount = 0;
    int errorCount = 0;

    logic [OUT_W-1:0] expQ[$];
    logic             modelReady;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Extension expressed as integer arithmetic on the immediate's value.
    function automatic logic [OUT_W-1:0] refExtend(input logic [IN_W-1:0] imm, input logic [1:0] mode);
        longint uval;
        longint sval;
        uval = longint'(imm);
        sval = imm[IN_W-1] ? uval - (longint'(1) << IN_W) : uval;
        case (mode)
            2'd0: return OUT_W'(uval);
            2'd1: return OUT_W'(sval);
            2'd2: return OUT_W'(uval * (longint'(1) << (OUT_W - IN_W)));
`ifdef IMM_EXT_BRANCH_EN
            default: return OUT_W'(sval * 4);
`else
            default: return OUT_W'(sval);
`endif
        endcase
    endfunction

    task automatic checkOutputs(input string tag);
        checkValue({tag, ".valid"}, 64'(OutValid), 64'(expQ.size() != 0));
        checkValue({tag, ".data"}, 64'(ImExtend), 64'((expQ.size() != 0) ? expQ[0] : '0));
        checkValue({tag, ".count"}, 64'(Count), 64'(expQ.size()));
        checkValue({tag, ".ready"}, 64'(InReady), 64'(modelReady));
    endtask

    // Called just after a falling edge: drive, take one rising edge, update model, check at next fall.
    task automatic cycle(input string tag, input logic valid, input logic [IN_W-1:0] imm,
                         input logic [1:0] mode, input logic outRdy);
        logic doPush;
        logic doPop;
        InValid   = valid;
        Immediate = imm;
        ExtMode   = mode;
        OutReady  = outRdy;
        doPush = valid && modelReady;
        doPop  = (expQ.size() != 0) && outRdy;
        @(posedge CLK);
        if (doPop)  void'(expQ.pop_front());
        if (doPush) expQ.push_back(refExtend(imm, mode));
        modelReady = (expQ.size() < DEPTH);
        @(negedge CLK);
        checkOutputs(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle("drain", 1'b0, '0, 2'd0, 1'b1);
        end
    endtask

    logic [OUT_W-1:0] mode3Exp;

    initial begin
        Reset_n    = 1'b0;
        InValid    = 1'b0;
        Immediate  = '0;
        ExtMode    = 2'd0;
        OutReady   = 1'b0;
        modelReady = 1'b0;

        // Reset held across a few edges
        #1;
        checkOutputs("rst0");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutputs("rst_hold");
        end
        #1 Reset_n = 1'b1;
        #1 checkValue("rst_release_ready_low", 64'(InReady), 64'd0);
        @(negedge CLK);
        modelReady = 1'b1;
        checkOutputs("rst_after_edge");
        checkValue("ready_after_release", 64'(InReady), 64'd1);

        // Each mode on 0x8007
`ifdef IMM_EXT_BRANCH_EN
        mode3Exp = 32'hFFFE001C;
`else
        mode3Exp = 32'hFFFF8007;
`endif
        cycle("mode0", 1'b1, 16'h8007, 2'd0, 1'b1);
        checkValue("mode0_const", 64'(ImExtend), 64'h00008007);
        cycle("mode1", 1'b1, 16'h8007, 2'd1, 1'b1);
        checkValue("mode1_const", 64'(ImExtend), 64'hFFFF8007);
        cycle("mode2", 1'b1, 16'h8007, 2'd2, 1'b1);
        checkValue("mode2_const", 64'(ImExtend), 64'h80070000);
        cycle("mode3", 1'b1, 16'h8007, 2'd3, 1'b1);
        checkValue("mode3_const", 64'(ImExtend), 64'(mode3Exp));
        drain();

        // Backpressure fills the buffer; third input must be refused
        cycle("bp_push1", 1'b1, 16'h0007, 2'd1, 1'b0);
        cycle("bp_push2", 1'b1, 16'h000A, 2'd1, 1'b0);
        checkValue("bp_count_full", 64'(Count), 64'd2);
        checkValue("bp_ready_low", 64'(InReady), 64'd0);
        checkValue("bp_head", 64'(ImExtend), 64'h00000007);
        cycle("bp_push3", 1'b1, 16'h0055, 2'd1, 1'b0);
        checkValue("bp_third_count", 64'(Count), 64'd2);
        checkValue("bp_hold_head", 64'(ImExtend), 64'h00000007);

        // Single pop from full
        cycle("full_pop", 1'b0, '0, 2'd0, 1'b1);
        checkValue("full_pop_count", 64'(Count), 64'd1);
        checkValue("full_pop_ready", 64'(InReady), 64'd1);
        checkValue("full_pop_head", 64'(ImExtend), 64'h0000000A);
        drain();

        // Streaming 1..10 through the wrapping pointers
        for (int i = 1; i <= 10; i++) begin
            cycle("stream", 1'b1, IN_W'(i), 2'd0, 1'b1);
            checkValue("stream_value", 64'(ImExtend), 64'(i));
            checkValue("stream_count", 64'(Count), 64'd1);
        end
        drain();

        // Asynchronous reset mid-stream
        cycle("mid_push1", 1'b1, 16'h1111, 2'd0, 1'b0);
        cycle("mid_push2", 1'b1, 16'h2222, 2'd0, 1'b0);
        #1 Reset_n = 1'b0;
        #1;
        checkValue("mid_rst_valid", 64'(OutValid), 64'd0);
        checkValue("mid_rst_count", 64'(Count), 64'd0);
        checkValue("mid_rst_data", 64'(ImExtend), 64'd0);
        checkValue("mid_rst_ready", 64'(InReady), 64'd0);
        expQ.delete();
        modelReady = 1'b0;
        #1 Reset_n = 1'b1;
        cycle("post_rst_idle", 1'b0, '0, 2'd0, 1'b0);
        cycle("post_rst_push", 1'b1, 16'h0033, 2'd0, 1'b0);
        checkValue("post_rst_data", 64'(ImExtend), 64'h00000033);
        checkValue("post_rst_count", 64'(Count), 64'd1);
        drain();

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), IN_W'($urandom), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
